// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register and writeback formatting for the 5-stage MIPS core.
// Captures memory-stage results, selects the writeback source (ALU result,
// big-endian formatted load data or link address), and drives the register
// file write port directly. Also keeps a retired-instruction counter.
//
// Optional feature macro: WB_MISALIGN_CHK_EN
//   Defined   : misaligned LW/LH/LHU loads raise misalign_o and suppress the
//               register-file write (the instruction still counts as retired).
//   Undefined : misalign_o is tied low and no write suppression happens.
//
// Parameters:
//   WIDTH       datapath width
//   ADDR_WIDTH  register address width
//   CNT_WIDTH   retire counter width
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall_i           hold the WB register contents
//   flush_i           load a bubble into the WB register (wins over stall_i)
//   mem_valid_i       MEM slot holds a real instruction
//   mem_reg_write_i   instruction writes a GPR
//   mem_dst_i         destination register
//   mem_wb_sel_i      writeback source: 00 ALU, 01 load, 10 link, 11 ALU
//   mem_ld_type_i     load format: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
//   mem_alu_result_i  ALU result, also the load address
//   mem_rdata_i       data-memory read word
//   mem_pc_plus8_i    link address for JAL/JALR
//   W_data, W_addr    register-file write data / address
//   RegWrite          register-file write enable
//   wb_valid_o        WB slot holds a real instruction
//   retire_cnt_o      number of retired instructions (wraps silently)
//   misalign_o        misaligned-load flag
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  mem_valid_i,
    input  logic                  mem_reg_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_dst_i,
    input  logic [1:0]            mem_wb_sel_i,
    input  logic [2:0]            mem_ld_type_i,
    input  logic [WIDTH-1:0]      mem_alu_result_i,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    input  logic [WIDTH-1:0]      mem_pc_plus8_i,
    output logic [WIDTH-1:0]      W_data,
    output logic [ADDR_WIDTH-1:0] W_addr,
    output logic                  RegWrite,
    output logic                  wb_valid_o,
    output logic [CNT_WIDTH-1:0]  retire_cnt_o,
    output logic                  misalign_o
);

    typedef enum logic [1:0] {
        WB_ALU   = 2'b00,
        WB_LOAD  = 2'b01,
        WB_LINK  = 2'b10,
        WB_ALU_X = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_H  = 3'b001,
        LD_HU = 3'b010,
        LD_B  = 3'b011,
        LD_BU = 3'b100
    } ld_type_e;

    // WB pipeline register fields
    logic                  valid_q;
    logic                  reg_write_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [1:0]            sel_q;
    logic [2:0]            ld_type_q;
    logic [WIDTH-1:0]      alu_q;
    logic [WIDTH-1:0]      rdata_q;
    logic [WIDTH-1:0]      pc8_q;
    logic [CNT_WIDTH-1:0]  retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            dst_q       <= '0;
            sel_q       <= '0;
            ld_type_q   <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc8_q       <= '0;
        end else if (flush_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            dst_q       <= '0;
            sel_q       <= '0;
            ld_type_q   <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc8_q       <= '0;
        end else if (!stall_i) begin
            valid_q     <= mem_valid_i;
            reg_write_q <= mem_reg_write_i;
            dst_q       <= mem_dst_i;
            sel_q       <= mem_wb_sel_i;
            ld_type_q   <= mem_ld_type_i;
            alu_q       <= mem_alu_result_i;
            rdata_q     <= mem_rdata_i;
            pc8_q       <= mem_pc_plus8_i;
        end
    end

    // An instruction retires on the edge where it leaves the WB slot; a held
    // or flushed slot does not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (valid_q && !stall_i && !flush_i) begin
            retire_cnt_q <= retire_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Big-endian lane selection: lower address picks the more significant lane.
    logic [1:0]       addr_lo;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [WIDTH-1:0] load_data;
    logic             misalign;

    always_comb begin
        addr_lo  = alu_q[1:0];
        half_sel = addr_lo[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (addr_lo)
            2'd0:    byte_sel = rdata_q[31:24];
            2'd1:    byte_sel = rdata_q[23:16];
            2'd2:    byte_sel = rdata_q[15:8];
            default: byte_sel = rdata_q[7:0];
        endcase
    end

    always_comb begin
        load_data = rdata_q;
        case (ld_type_q)
            LD_H:    load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
            LD_HU:   load_data = {{(WIDTH-16){1'b0}}, half_sel};
            LD_B:    load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_BU:   load_data = {{(WIDTH-8){1'b0}}, byte_sel};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        case (sel_q)
            WB_LOAD: W_data = load_data;
            WB_LINK: W_data = pc8_q;
            default: W_data = alu_q;
        endcase
    end

`ifdef WB_MISALIGN_CHK_EN
    // Halfwords need a[0]=0; LW and unused codes need a word-aligned address.
    always_comb begin
        misalign = 1'b0;
        if (valid_q && (sel_q == WB_LOAD)) begin
            case (ld_type_q)
                LD_H, LD_HU:  misalign = addr_lo[0];
                LD_B, LD_BU:  misalign = 1'b0;
                default:      misalign = (addr_lo != 2'd0);
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign W_addr       = dst_q;
    assign RegWrite     = valid_q & reg_write_q & (dst_q != '0) & ~misalign;
    assign wb_valid_o   = valid_q;
    assign retire_cnt_o = retire_cnt_q;
    assign misalign_o   = misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Self-checking bench for mem_wb_stage. A behavioural model holds the
// instruction currently in WB as a plain record and derives the expected
// writeback value by shifting/masking the read word; a second instance with a
// 3-bit retire counter exercises counter wrap-around.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        in_valid, in_rw;
    logic [4:0]  in_dst;
    logic [1:0]  in_sel;
    logic [2:0]  in_ld;
    logic [31:0] in_alu, in_rd, in_pc8;

    logic [31:0] W_data;
    logic [4:0]  W_addr;
    logic        RegWrite, wb_valid, misalign;
    logic [31:0] retire_cnt;

    logic [31:0] n_wdata;
    logic [4:0]  n_waddr;
    logic        n_regwrite, n_valid, n_misalign;
    logic [2:0]  n_cnt;

    always #5 clk = ~clk;

    mem_wb_stage #(.WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .mem_valid_i(in_valid), .mem_reg_write_i(in_rw), .mem_dst_i(in_dst),
        .mem_wb_sel_i(in_sel), .mem_ld_type_i(in_ld), .mem_alu_result_i(in_alu),
        .mem_rdata_i(in_rd), .mem_pc_plus8_i(in_pc8),
        .W_data(W_data), .W_addr(W_addr), .RegWrite(RegWrite),
        .wb_valid_o(wb_valid), .retire_cnt_o(retire_cnt), .misalign_o(misalign)
    );

    mem_wb_stage #(.WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(3)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .mem_valid_i(in_valid), .mem_reg_write_i(in_rw), .mem_dst_i(in_dst),
        .mem_wb_sel_i(in_sel), .mem_ld_type_i(in_ld), .mem_alu_result_i(in_alu),
        .mem_rdata_i(in_rd), .mem_pc_plus8_i(in_pc8),
        .W_data(n_wdata), .W_addr(n_waddr), .RegWrite(n_regwrite),
        .wb_valid_o(n_valid), .retire_cnt_o(n_cnt), .misalign_o(n_misalign)
    );

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [4:0]  dst;
        logic [1:0]  sel;
        logic [2:0]  ld;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc8;
    } slot_t;

    slot_t       m;
    int unsigned cnt_m;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Big-endian extraction: address a selects the lane starting a bytes from the MSB.
    function automatic logic [31:0] load_fmt(input slot_t s);
        logic [31:0] word_sh;
        logic [15:0] h;
        logic [7:0]  b;
        int          a;
        a       = int'(s.alu[1:0]);
        word_sh = s.rd >> (16 * (1 - a / 2));
        h       = word_sh[15:0];
        word_sh = s.rd >> (8 * (3 - a));
        b       = word_sh[7:0];
        case (s.ld)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            default: return s.rd;
        endcase
    endfunction

    function automatic logic exp_mis(input slot_t s);
`ifdef WB_MISALIGN_CHK_EN
        if (!s.v || s.sel != 2'd1) return 1'b0;
        if (s.ld == 3'd1 || s.ld == 3'd2) return s.alu[0];
        if (s.ld == 3'd3 || s.ld == 3'd4) return 1'b0;
        return s.alu[1:0] != 2'd0;
`else
        return (s.v && 1'b0);
`endif
    endfunction

    function automatic logic [31:0] exp_wdata(input slot_t s);
        if (s.sel == 2'd1) return load_fmt(s);
        if (s.sel == 2'd2) return s.pc8;
        return s.alu;
    endfunction

    function automatic logic exp_rw(input slot_t s);
        return s.v && s.rw && (s.dst != 5'd0) && !exp_mis(s);
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".wdata"}, W_data, exp_wdata(m));
        check({tag, ".waddr"}, 32'(W_addr), 32'(m.dst));
        check({tag, ".regwrite"}, 32'(RegWrite), 32'(exp_rw(m)));
        check({tag, ".valid"}, 32'(wb_valid), 32'(m.v));
        check({tag, ".misalign"}, 32'(misalign), 32'(exp_mis(m)));
        check({tag, ".cnt"}, retire_cnt, cnt_m);
        check({tag, ".n_cnt"}, 32'(n_cnt), cnt_m % 8);
        check({tag, ".n_wdata"}, n_wdata, exp_wdata(m));
        check({tag, ".n_waddr"}, 32'(n_waddr), 32'(m.dst));
        check({tag, ".n_rw"}, 32'(n_regwrite), 32'(exp_rw(m)));
        check({tag, ".n_valid"}, 32'(n_valid), 32'(m.v));
        check({tag, ".n_mis"}, 32'(n_misalign), 32'(exp_mis(m)));
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] dst,
                         input logic [1:0] sel, input logic [2:0] ld,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] pc8);
        in_valid = v;   in_rw = rw;   in_dst = dst; in_sel = sel;
        in_ld    = ld;  in_alu = alu; in_rd  = rd;  in_pc8 = pc8;
    endtask

    // One clock: model update at the edge, outputs compared on the falling edge.
    task automatic tick(input logic st, input logic fl, input string tag);
        stall = st;
        flush = fl;
        @(posedge clk);
        if (m.v && !st && !fl) cnt_m++;
        if (fl) m = '0;
        else if (!st) m = '{in_valid, in_rw, in_dst, in_sel, in_ld, in_alu, in_rd, in_pc8};
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        m     = '0;
        cnt_m = 0;
        drive(1'b1, 1'b1, 5'd9, 2'd2, 3'd0, 32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444);
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;
        idle();
        tick(1'b0, 1'b0, "idle0");
        tick(1'b0, 1'b0, "idle1");

        // ALU writeback
        drive(1'b1, 1'b1, 5'd8, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
        tick(1'b0, 1'b0, "alu");
        check("alu.lit_wdata", W_data, 32'h0000_1234);
        check("alu.lit_rw", 32'(RegWrite), 32'd1);
        idle();
        tick(1'b0, 1'b0, "alu_after");
        check("alu.lit_cnt", retire_cnt, 32'd1);

        // Loads from 0x80FF_7F01
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd3, 32'h100, 32'h80FF_7F01, 32'h0);
        tick(1'b0, 1'b0, "lb0");
        check("lb0.lit", W_data, 32'hFFFF_FF80);
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd4, 32'h101, 32'h80FF_7F01, 32'h0);
        tick(1'b0, 1'b0, "lbu1");
        check("lbu1.lit", W_data, 32'h0000_00FF);
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd1, 32'h102, 32'h80FF_7F01, 32'h0);
        tick(1'b0, 1'b0, "lh2");
        check("lh2.lit", W_data, 32'h0000_7F01);
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd1, 32'h100, 32'h80FF_7F01, 32'h0);
        tick(1'b0, 1'b0, "lh0");
        check("lh0.lit", W_data, 32'hFFFF_80FF);
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd0, 32'h100, 32'h80FF_7F01, 32'h0);
        tick(1'b0, 1'b0, "lw");
        check("lw.lit", W_data, 32'h80FF_7F01);

        // dst=0 never writes but still retires; link source
        drive(1'b1, 1'b1, 5'd0, 2'd2, 3'd0, 32'h5, 32'h0, 32'h0040_0008);
        tick(1'b0, 1'b0, "dst0");
        check("dst0.lit_rw", 32'(RegWrite), 32'd0);
        check("dst0.lit_wdata", W_data, 32'h0040_0008);

        // Stall for 3 cycles: held outputs, one count on release
        drive(1'b1, 1'b1, 5'd17, 2'd0, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0);
        tick(1'b0, 1'b0, "st_load");
        drive(1'b1, 1'b1, 5'd20, 2'd2, 3'd0, 32'h0, 32'h0, 32'h7777_0000);
        for (int unsigned i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, "stall");
            check("stall.lit_wdata", W_data, 32'hCAFE_0001);
        end
        tick(1'b0, 1'b0, "st_release");

        // Stall together with flush: bubble wins, valid slot not counted
        tick(1'b1, 1'b1, "stflush");
        check("stflush.lit_valid", 32'(wb_valid), 32'd0);
        idle();
        tick(1'b0, 1'b0, "post_flush");

`ifdef WB_MISALIGN_CHK_EN
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd0, 32'h102, 32'h80FF_7F01, 32'h0);
        tick(1'b0, 1'b0, "mis_lw2");
        check("mis_lw2.lit", {30'd0, misalign, RegWrite}, 32'd2);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd1, 32'h101, 32'h80FF_7F01, 32'h0);
        tick(1'b0, 1'b0, "mis_lh1");
        check("mis_lh1.lit", {30'd0, misalign, RegWrite}, 32'd2);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd3, 32'h103, 32'h80FF_7F01, 32'h0);
        tick(1'b0, 1'b0, "mis_lb3");
        check("mis_lb3.lit", {30'd0, misalign, RegWrite}, 32'd1);
`endif

        // Randomized traffic
        for (int unsigned i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
            tick(($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), "rand");
        end

        // Asynchronous reset while a valid instruction is stalled in WB
        drive(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'h0BAD_F00D, 32'h0, 32'h0);
        tick(1'b0, 1'b0, "pre_rst");
        tick(1'b1, 1'b0, "pre_rst_stall");
        #2;
        rst_n = 1'b0;
        #1;
        m     = '0;
        cnt_m = 0;
        compare_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, "post_rst");
        idle();
        tick(1'b0, 1'b0, "post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
